fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Drain-side controller for a show-ahead synchronous FIFO: reads `rd_data`, drives `rd_en`, observes `empty`.
- Per accepted command, pops exactly `cmd_len_i` words and presents them on a registered valid/ready stream.
- Asserts `m_last_o` on the final word and pulses `done_o` when the burst has fully left the block.
- Sits between the data FIFOs and downstream consumers (DMA/compute engines) that need length-framed bursts.

Parameters:
- DATA_WTH, 8, width of FIFO word and stream data.
- LEN_WTH, 8, width of burst length field; max burst is 2^LEN_WTH-1 words.

Ports:
- `clk_i`, input, 1, clock.
- `rst_n_i`, input, 1, reset, asynchronous, active-low.
- `cmd_valid_i`, input, 1, burst command valid.
- `cmd_len_i`, input, LEN_WTH, number of words to drain.
- `cmd_ready_o`, output, 1, command accepted when `cmd_valid_i` and `cmd_ready_o` are both high at a clock edge.
- `fifo_rd_data_i`, input, DATA_WTH, FIFO head word, valid whenever `fifo_empty_i` is low.
- `fifo_empty_i`, input, 1, FIFO empty.
- `fifo_rd_en_o`, output, 1, pops the FIFO head at the clock edge.
- `m_data_o`, output, DATA_WTH, stream data, registered.
- `m_valid_o`, output, 1, stream valid, registered.
- `m_last_o`, output, 1, final beat of burst, registered.
- `m_ready_i`, input, 1, downstream ready.
- `busy_o`, output, 1, high whenever state is not IDLE.
- `done_o`, output, 1, one-cycle burst completion pulse.

Behaviour:
- Reset (async assert, sync deassert by integrator):
  - state=IDLE, rem=0, output buffer empty.
  - `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `done_o`=0, `busy_o`=0, `cmd_ready_o`=1, `fifo_rd_en_o`=0.
- States:
  - IDLE: `cmd_ready_o`=1. On accept, rem<=`cmd_len_i`. If `cmd_len_i`!=0 go to BURST, else go to DONE.
  - BURST: pops words. When the pop with rem==1 occurs, go to FLUSH.
  - FLUSH: wait until the output buffer is empty (last beat handshaken), then go to DONE.
  - DONE: `done_o`=1 for exactly one cycle, then go to IDLE.
- Pop rule: `fifo_rd_en_o` = (state==BURST) & (rem!=0) & ~`fifo_empty_i` & (occ<2).
  - occ is the registered output-buffer occupancy (0..2).
  - The pop rule must not depend combinationally on `m_ready_i`.
  - Each pop decrements rem by 1. rem never underflows.
- Output buffer: 2-entry skid (main register + skid register). Each entry holds {last, data}.
  - last is set on the entry popped when rem==1.
  - `m_valid_o`/`m_data_o`/`m_last_o` come from the main register.
  - While `m_valid_o`=1 and `m_ready_i`=0, data and last are held stable.
  - A beat transfers when `m_valid_o` & `m_ready_i` at a clock edge. A simultaneous pop and transfer leaves occ unchanged.
- Throughput and latency:
  - Full rate of 1 word/cycle when the FIFO is non-empty and `m_ready_i`=1.
  - Command accepted at edge T → first pop in cycle T+1 (if FIFO non-empty) → `m_valid_o` high from cycle T+2.
  - Final beat handshake at edge E → state DONE with `done_o`=1 in cycle E+1 → `cmd_ready_o`=1 in cycle E+2.
- FIFO empty mid-burst: pops stall and rem is held. Output drains normally. Popping resumes when `fifo_empty_i` falls. No timeout.
- Zero-length command: no pop and no beat. `done_o` pulses in the cycle after acceptance.
- `cmd_valid_i` while busy: ignored (`cmd_ready_o`=0). No queuing.
- `rst_n_i` asserted mid-burst: everything clears immediately.
  - Words already popped but not transferred are discarded.
  - FIFO contents and pointers are the FIFO's responsibility.
  - No `done_o` is issued for the aborted burst.

Decomposition:
- Shared package (e.g. `hpu_stream_pkg`): state encoding localparams (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2, DONE=2'd3) and the default widths.
- One sub-module: `stream_skid_buf` (params DATA_WTH+1), 2-entry registered valid/ready buffer.
  - Exposes occ (or an `almost_full`) to the parent.
  - The parent holds the FSM, the rem counter and the pop logic.

Test Plan:
1. FIFO preloaded with 0x10..0x13, cmd_len=4, `m_ready_i`=1 → 4 beats on consecutive cycles, data 0x10,0x11,0x12,0x13, `m_last_o` only on 0x13. `done_o` one cycle after the last beat. Exactly 4 `fifo_rd_en_o` pulses.
2. Same as 1 but `m_ready_i` toggles 1,0,0,1,... → data held stable while not ready. occ never exceeds 2. No pop occurs while occ==2. Order preserved, no duplicates.
3. cmd_len=3 with the FIFO holding 1 word, 2 more written 5 cycles later → first beat, then a stall with rem=2 and `busy_o`=1. Remaining 2 beats after the writes, last on the 3rd. `done_o` once.
4. cmd_len=0 → `cmd_ready_o` drops for 1 cycle, `done_o` pulses in the next cycle, `m_valid_o` stays 0, no pops.
5. cmd_len=255 with continuous FIFO supply and ready → 255 beats in 255 cycles. `m_last_o` on beat 255 only. A second command presented during the burst is not accepted until after `done_o`.
6. `rst_n_i` asserted asynchronously mid-clock after 2 of 6 beats → `m_valid_o`, `busy_o` and `fifo_rd_en_o` go 0 immediately. After release, `cmd_ready_o`=1 and no `done_o` appears for the aborted burst.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader.
//   - Default data/length widths.
//   - Controller state encoding.
//   - Occupancy level at which the output buffer can take no more words.
package fifo_burst_reader_pkg;

  localparam int DATA_WTH_DEF = 8;
  localparam int LEN_WTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] OCC_FULL = 2'd2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered valid/ready buffer (main register + skid register).
// Ports:
//   clk_i, rst_n_i  : clock, asynchronous active-low reset
//   in_valid_i      : write strobe; the writer must keep it low when occ_o is full
//   in_data_i       : word to store
//   out_valid_o     : main register holds a word
//   out_data_o      : main register contents (held while not accepted)
//   out_ready_i     : consumer accepts the main word at the clock edge
//   occ_o           : registered occupancy 0..2
module stream_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int WTH = DATA_WTH_DEF + 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           in_valid_i,
  input  logic [WTH-1:0] in_data_i,
  output logic           out_valid_o,
  output logic [WTH-1:0] out_data_o,
  input  logic           out_ready_i,
  output logic [1:0]     occ_o
);

  logic [WTH-1:0] main_q, main_d;
  logic [WTH-1:0] skid_q, skid_d;
  logic [1:0]     occ_q, occ_d;
  logic           xfer;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    xfer   = (occ_q != 2'd0) && out_ready_i;
    case (occ_q)
      2'd0: begin
        if (in_valid_i) begin
          main_d = in_data_i;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        // Write and read in the same cycle: new word goes straight to main.
        if (in_valid_i && xfer) begin
          main_d = in_data_i;
        end else if (in_valid_i) begin
          skid_d = in_data_i;
          occ_d  = OCC_FULL;
        end else if (xfer) begin
          occ_d  = 2'd0;
        end
      end
      default: begin
        if (xfer) begin
          main_d = skid_q;
          occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_q <= '0;
      skid_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = main_q;
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drain-side controller for a show-ahead FIFO. Each accepted command pops
// exactly cmd_len_i words and presents them on a registered valid/ready
// stream, flagging the final word with m_last_o and pulsing done_o once the
// burst has fully left the block.
// Ports:
//   clk_i, rst_n_i              : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_len_i/cmd_ready_o : burst command handshake
//   fifo_rd_data_i/fifo_empty_i : FIFO head word and empty flag
//   fifo_rd_en_o                : pops the FIFO head at the clock edge
//   m_data_o/m_valid_o/m_last_o/m_ready_i : registered output stream
//   busy_o                      : controller not idle
//   done_o                      : one-cycle burst completion pulse
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WTH = DATA_WTH_DEF,
  parameter int LEN_WTH  = LEN_WTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  input  logic [LEN_WTH-1:0]  cmd_len_i,
  output logic                cmd_ready_o,
  input  logic [DATA_WTH-1:0] fifo_rd_data_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_en_o,
  output logic [DATA_WTH-1:0] m_data_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [LEN_WTH-1:0] LEN_ONE = LEN_WTH'(1);

  state_e             state_q, state_d;
  logic [LEN_WTH-1:0] rem_q, rem_d;
  logic [1:0]         occ;
  logic               pop;
  logic               last_pop;
  logic [DATA_WTH:0]  buf_out;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    // Pop depends only on registered occupancy, never on m_ready_i.
    pop      = (state_q == ST_BURST) && (rem_q != '0) && !fifo_empty_i && (occ < OCC_FULL);
    last_pop = pop && (rem_q == LEN_ONE);
    if (pop) begin
      rem_d = rem_q - LEN_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          rem_d   = cmd_len_i;
          state_d = (cmd_len_i != '0) ? ST_BURST : ST_DONE;
        end
      end
      ST_BURST: begin
        if (last_pop) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave on the handshake of the final beat so done_o follows it directly.
        if (m_valid_o && m_ready_i && m_last_o) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  stream_skid_buf #(
    .WTH (DATA_WTH + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (pop),
    .in_data_i   ({last_pop, fifo_rd_data_i}),
    .out_valid_o (m_valid_o),
    .out_data_o  (buf_out),
    .out_ready_i (m_ready_i),
    .occ_o       (occ)
  );

  assign m_last_o     = buf_out[DATA_WTH];
  assign m_data_o     = buf_out[DATA_WTH-1:0];
  assign fifo_rd_en_o = pop;
  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [LW-1:0] cmd_len;
  logic          cmd_ready;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WTH(DW), .LEN_WTH(LW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_len_i      (cmd_len),
    .cmd_ready_o    (cmd_ready),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_last_o       (m_last),
    .m_ready_i      (m_ready),
    .busy_o         (busy),
    .done_o         (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO contents, words scheduled for a later write, and expected beats.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] late_q[$];
  logic [DW-1:0] exp_q[$];

  int            cyc = 0;
  int            late_cyc = 0;
  int            ready_mode = 0;
  logic          want_cmd = 1'b0;
  logic [LW-1:0] want_len = '0;

  bit            s_pop, s_accept, prev_pop, prev_stall, burst_open;
  logic [DW:0]   prev_beat;
  int            burst_len, pops, beats, accept_cyc, first_xfer_cyc, last_xfer_cyc;
  int            done_cyc = -10;

  task automatic drive_fifo();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic sample();
    logic [DW-1:0] e;
    int occ_model;
    check("ready_vs_busy", cmd_ready, !busy);
    if (burst_open && cyc > accept_cyc) check("busy_in_burst", busy, 1);
    if (prev_stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_beat", {m_last, m_data}, prev_beat);
    end
    if (prev_pop) check("valid_after_pop", m_valid, 1);
    if (burst_open && burst_len != 0 && cyc == accept_cyc + 1)
      check("first_pop", fifo_rd_en, !fifo_empty);
    if (fifo_rd_en) begin
      occ_model = pops - beats;
      check("pop_nonempty", fifo_empty, 0);
      check("pop_room", occ_model < 2, 1);
      check("pop_count", pops < burst_len, 1);
      pops++;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        beats++;
        check("beat_data", m_data, e);
        check("beat_last", m_last, beats == burst_len);
        if (beats == 1) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
    end
    if (done) begin
      check("done_expected", burst_open, 1);
      check("done_timing", cyc, (burst_len == 0) ? accept_cyc + 1 : last_xfer_cyc + 1);
      check("done_beats", beats, burst_len);
      check("done_pops", pops, burst_len);
      done_cyc   = cyc;
      burst_open = 1'b0;
    end
    if (cyc == done_cyc + 1) check("ready_after_done", cmd_ready, 1);
    s_accept = cmd_valid && cmd_ready;
    if (s_accept) begin
      check("accept_idle", burst_open, 0);
      burst_open = 1'b1;
      accept_cyc = cyc;
      burst_len  = int'(cmd_len);
      pops       = 0;
      beats      = 0;
    end
    s_pop      = fifo_rd_en;
    prev_pop   = fifo_rd_en;
    prev_stall = m_valid && !m_ready;
    prev_beat  = {m_last, m_data};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (s_pop && fq.size() > 0) void'(fq.pop_front());
    if (late_q.size() > 0 && cyc >= late_cyc)
      while (late_q.size() > 0) fq.push_back(late_q.pop_front());
    drive_fifo();
    cmd_valid = want_cmd;
    cmd_len   = want_len;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (cyc % 3 == 0);
    endcase
    #2;
    sample();
  endtask

  task automatic run_burst(input int len, input int npre, input int late, input int mode,
                           input int base, input bit chain);
    logic [DW-1:0] w;
    int n;
    ready_mode = mode;
    for (int i = 0; i < len; i++) begin
      w = (base < 0) ? DW'($urandom) : DW'(base + i);
      exp_q.push_back(w);
      if (i < npre) fq.push_back(w);
      else late_q.push_back(w);
    end
    late_cyc = cyc + late;
    want_cmd = 1'b1;
    want_len = LW'(len);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_accept && n < 20);
    check("cmd_accepted", s_accept, 1);
    want_cmd = chain;
    want_len = '0;
    n = 0;
    while (burst_open && n < len * 12 + 60) begin
      tick();
      n++;
    end
    check("burst_finished", burst_open, 0);
    if (mode == 0 && npre == len && len > 0)
      check("full_rate", last_xfer_cyc - first_xfer_cyc, len - 1);
    if (chain) begin
      tick();
      check("chain_accept", s_accept, 1);
      want_cmd = 1'b0;
      n = 0;
      while (burst_open && n < 20) begin
        tick();
        n++;
      end
      check("chain_finished", burst_open, 0);
    end
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int n;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_len      = '0;
    m_ready      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", fifo_rd_en, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    run_burst(4, 4, 0, 0, 'h10, 1'b0);     // preloaded, always ready
    run_burst(4, 4, 0, 2, 'h20, 1'b0);     // ready pattern 1,0,0
    run_burst(3, 1, 5, 0, 'h30, 1'b0);     // FIFO runs dry mid-burst
    run_burst(0, 0, 0, 0, 0, 1'b0);        // zero-length command
    run_burst(255, 255, 0, 0, -1, 1'b1);   // max length, second command held off
    for (int k = 0; k < 8; k++)
      run_burst($urandom_range(0, 20), 0, $urandom_range(1, 8), 1, -1, 1'b0);
    for (int k = 0; k < 4; k++)
      run_burst($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 8), 1, -1, 1'b0);

    // Abort a 6-word burst after two beats.
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom);
      fq.push_back(w);
      exp_q.push_back(w);
    end
    want_cmd = 1'b1;
    want_len = LW'(6);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_accept && n < 20);
    want_cmd = 1'b0;
    n = 0;
    while (beats < 2 && n < 20) begin
      tick();
      n++;
    end
    check("abort_point", beats, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_m_valid", m_valid, 0);
    check("abort_m_data", m_data, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_en", fifo_rd_en, 0);
    burst_open = 1'b0;
    exp_q.delete();
    fq.delete();
    late_q.delete();
    s_pop      = 1'b0;
    prev_pop   = 1'b0;
    prev_stall = 1'b0;
    pops       = 0;
    beats      = 0;
    drive_fifo();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_ready", cmd_ready, 1);
    run_burst(3, 3, 0, 1, 'h50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
